// File: rtl/mfm_encoder.sv
// mfm_encoder: serialises bytes into a raw MFM write-pulse stream.
// Each data bit spans a clock window followed by a data window, each
// WINDOW_CLKS cycles long; pulses sit at the start of a window and last
// PULSE_CLKS cycles. A holding register plus a shift register allow
// back-to-back bytes with no gap.
// Optional feature macro: MFM_ENC_SYNC_EN (per-byte missing-clock mark on
// the clock window of data_in[2], turning 0xA1 into 0x4489).
module mfm_encoder #(
  parameter int WINDOW_CLKS = 5,
  parameter int PULSE_CLKS  = 5
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       data_sync,
  output logic       raw_mfm,
  output logic       write_gate,
  output logic       busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CLK_WIN  = 2'd1;
  localparam logic [1:0] DATA_WIN = 2'd2;

  localparam logic [7:0] WIN_LAST  = 8'(WINDOW_CLKS - 1);
  localparam logic [7:0] PULSE_LIM = 8'(PULSE_CLKS);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       prev_q, prev_d;
  logic [7:0] hold_q, hold_d;
  logic       holdFull_q, holdFull_d;
  logic       reload;
  logic       accept;
  logic       clkSuppress;
  logic       pulse_d;
  logic       rawMfm_d;

  assign accept = data_valid && data_ready;

`ifdef MFM_ENC_SYNC_EN
  logic holdSync_q, holdSync_d;
  logic shiftSync_q, shiftSync_d;

  // Carry the sync flag alongside its byte from holding to shift register
  always_comb begin
    holdSync_d  = holdSync_q;
    shiftSync_d = shiftSync_q;
    if (reload) shiftSync_d = holdSync_q;
    if (accept) holdSync_d = data_sync;
  end

  // Sync flag storage
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      holdSync_q  <= 1'b0;
      shiftSync_q <= 1'b0;
    end else begin
      holdSync_q  <= holdSync_d;
      shiftSync_q <= shiftSync_d;
    end
  end

  assign clkSuppress = shiftSync_d && (bit_d == 3'd5);
`else
  logic unusedSync;
  assign unusedSync  = data_sync;
  assign clkSuppress = 1'b0;
`endif

  // Window sequencing, bit shifting and holding-register handshake
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    prev_d     = prev_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    reload     = 1'b0;
    case (state_q)
      IDLE: begin
        if (holdFull_q) begin
          reload  = 1'b1;
          state_d = CLK_WIN;
          cnt_d   = 8'd0;
          prev_d  = 1'b0;
        end
      end
      CLK_WIN: begin
        if (cnt_q == WIN_LAST) begin
          cnt_d   = 8'd0;
          state_d = DATA_WIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA_WIN: begin
        if (cnt_q == WIN_LAST) begin
          cnt_d  = 8'd0;
          prev_d = shift_q[7];
          if (bit_q == 3'd7) begin
            if (holdFull_q) begin
              reload  = 1'b1;
              state_d = CLK_WIN;
            end else begin
              state_d = IDLE;
              prev_d  = 1'b0;
            end
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            state_d = CLK_WIN;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (reload) begin
      shift_d    = hold_q;
      bit_d      = 3'd0;
      holdFull_d = 1'b0;
    end
    if (accept) begin
      hold_d     = data_in;
      holdFull_d = 1'b1;
    end
  end

  // Pulse for the upcoming cycle, so raw_mfm lines up with write_gate
  always_comb begin
    pulse_d = 1'b0;
    case (state_d)
      CLK_WIN:  pulse_d = !prev_d && !shift_d[7] && !clkSuppress;
      DATA_WIN: pulse_d = shift_d[7];
      default:  pulse_d = 1'b0;
    endcase
    rawMfm_d = pulse_d && (cnt_d < PULSE_LIM);
  end

  // State, datapath and registered outputs; reset aborts everything at once
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      prev_q     <= 1'b0;
      hold_q     <= 8'd0;
      holdFull_q <= 1'b0;
      raw_mfm    <= 1'b0;
      write_gate <= 1'b0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      prev_q     <= prev_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      raw_mfm    <= rawMfm_d;
      write_gate <= (state_d != IDLE);
      busy       <= (state_d != IDLE) || holdFull_d;
      data_ready <= !holdFull_d;
    end
  end

endmodule

// File: tb/tb_mfm_encoder.sv
// Self-checking bench for mfm_encoder: table of single-byte vectors,
// hand-written multi-byte and reset sequences, and random streams checked
// against a bit-level MFM reference model.
module tb_mfm_encoder;

   localparam int WIN = 5;
   localparam int PUL = 5;
`ifdef MFM_ENC_SYNC_EN
   localparam bit SYNC_BUILD = 1'b1;
`else
   localparam bit SYNC_BUILD = 1'b0;
`endif

   logic       clk50;
   logic       reset;
   logic [7:0] dataIn;
   logic       dataValid;
   logic       dataReady;
   logic       dataSync;
   logic       rawMfm;
   logic       writeGate;
   logic       busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]  streamData[4];
   logic        streamSync[4];
   logic [15:0] expWords[4];
   int          streamLen;
   logic        lastSamples[$];

   typedef struct {
      logic [7:0]  data;
      logic        sync;
      logic [15:0] expWord;
   } vecT;

   vecT vecs[6];

   mfm_encoder #(.WINDOW_CLKS(WIN), .PULSE_CLKS(PUL)) dut (
      .clk_50(clk50),
      .reset(reset),
      .data_in(dataIn),
      .data_valid(dataValid),
      .data_ready(dataReady),
      .data_sync(dataSync),
      .raw_mfm(rawMfm),
      .write_gate(writeGate),
      .busy(busy)
   );

   // 50 MHz clock
   initial begin
      clk50 = 1'b0;
      forever #10 clk50 = ~clk50;
   end

   // Hard stop in case something hangs
   initial begin
      #4_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: MFM windows for one byte, window 0 in bit 15
   function automatic logic [15:0] mfmWord(input logic prevBit, input logic [7:0] b,
                                           input logic syncFlag);
      logic [15:0] word;
      logic        p;
      p = prevBit;
      word = 16'd0;
      for (int i = 7; i >= 0; i--) begin
         int slot;
         slot = 2 * (7 - i);
         word[15 - slot] = !p && !b[i] && !(syncFlag && SYNC_BUILD && i == 2);
         word[14 - slot] = b[i];
         p = b[i];
      end
      return word;
   endfunction

   task automatic checkSignal(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b required %b", name, actual, expected);
      end
   endtask

   // Offer each byte of the current stream as soon as data_ready allows
   task automatic applyStimulus();
      for (int i = 0; i < streamLen; i++) begin
         int waitCycles;
         waitCycles = 0;
         @(negedge clk50);
         while (!dataReady && waitCycles < 400) begin
            @(negedge clk50);
            waitCycles++;
         end
         if (!dataReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready-timeout byte %0d: data_ready=%b required 1", i, dataReady);
            return;
         end
         dataIn    = streamData[i];
         dataSync  = streamSync[i];
         dataValid = 1'b1;
         @(negedge clk50);
         dataValid = 1'b0;
         dataIn    = 8'($urandom);
         dataSync  = 1'($urandom);
         checkSignal("ready-low-after-accept", dataReady, 1'b0);
      end
   endtask

   // Capture the whole stream from write_gate rising and compare per window
   task automatic checkOutput(input string name);
      int   waitCycles;
      int   total;
      logic gateOk;
      lastSamples.delete();
      waitCycles = 0;
      @(negedge clk50);
      while (!writeGate && waitCycles < 50) begin
         @(negedge clk50);
         waitCycles++;
      end
      if (!writeGate) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s gate-rise-timeout: write_gate=%b required 1", name, writeGate);
         return;
      end
      checkSignal("busy-at-start", busy, 1'b1);
      total  = streamLen * 16 * WIN;
      gateOk = 1'b1;
      for (int t = 0; t < total; t++) begin
         if (t > 0) @(negedge clk50);
         lastSamples.push_back(rawMfm);
         if (writeGate !== 1'b1) gateOk = 1'b0;
      end
      checkSignal("gate-held-whole-stream", gateOk, 1'b1);
      @(negedge clk50);
      checkSignal("gate-falls-after-stream", writeGate, 1'b0);
      checkSignal("busy-clear-after-stream", busy, 1'b0);
      for (int w = 0; w < streamLen * 16; w++) begin
         logic [7:0] actMask;
         logic [7:0] expMask;
         logic       expBit;
         expBit  = expWords[w / 16][15 - (w % 16)];
         actMask = 8'd0;
         expMask = 8'd0;
         for (int off = 0; off < WIN; off++) begin
            actMask[off] = lastSamples[w * WIN + off];
            expMask[off] = expBit && (off < PUL);
         end
         checks++;
         if (actMask !== expMask) begin
            errors++;
            $display("[TB] FAIL %s window %0d: raw_mfm cycles %b required %b",
                     name, w, actMask, expMask);
         end
      end
   endtask

   task automatic runStream(input string name);
      fork
         applyStimulus();
         checkOutput(name);
      join
   endtask

   initial begin
      reset     = 1'b1;
      dataIn    = 8'd0;
      dataValid = 1'b0;
      dataSync  = 1'b0;

      vecs[0] = '{8'h00, 1'b0, 16'hAAAA};
      vecs[1] = '{8'hFF, 1'b0, 16'h5555};
      vecs[2] = '{8'hA1, 1'b0, 16'h44A9};
      vecs[3] = '{8'hA1, 1'b1, SYNC_BUILD ? 16'h4489 : 16'h44A9};
      vecs[4] = '{8'h01, 1'b0, 16'hAAA9};
      vecs[5] = '{8'h80, 1'b0, 16'h4AAA};

      // Reset state
      repeat (3) @(negedge clk50);
      checkSignal("reset raw_mfm", rawMfm, 1'b0);
      checkSignal("reset write_gate", writeGate, 1'b0);
      checkSignal("reset busy", busy, 1'b0);
      checkSignal("reset data_ready", dataReady, 1'b0);
      reset = 1'b0;
      @(negedge clk50);
      checkSignal("post-reset data_ready", dataReady, 1'b1);
      checkSignal("post-reset busy", busy, 1'b0);

      // Table of single-byte vectors
      for (int v = 0; v < 6; v++) begin
         streamLen     = 1;
         streamData[0] = vecs[v].data;
         streamSync[0] = vecs[v].sync;
         expWords[0]   = vecs[v].expWord;
         runStream($sformatf("vec%0d", v));
      end

      // Back-to-back 0x01, 0x80: no gap, no clock in window 16, data in 17
      streamLen = 2;
      streamData[0] = 8'h01; streamSync[0] = 1'b0; expWords[0] = 16'hAAA9;
      streamData[1] = 8'h80; streamSync[1] = 1'b0; expWords[1] = 16'h4AAA;
      runStream("b2b-01-80");
      checkSignal("b2b window16 no pulse",
                  (lastSamples.size() > 17 * WIN) ? lastSamples[16 * WIN] : 1'bx, 1'b0);
      checkSignal("b2b window17 pulse",
                  (lastSamples.size() > 17 * WIN) ? lastSamples[17 * WIN] : 1'bx, 1'b1);

      // prev_bit carried across bytes suppresses the first clock of 0x00
      streamLen = 2;
      streamData[0] = 8'h01; streamSync[0] = 1'b0; expWords[0] = 16'hAAA9;
      streamData[1] = 8'h00; streamSync[1] = 1'b0; expWords[1] = 16'h2AAA;
      runStream("b2b-01-00");

      // Reset in window 7 aborts immediately
      streamLen = 1;
      streamData[0] = 8'h00; streamSync[0] = 1'b0; expWords[0] = 16'hAAAA;
      fork
         applyStimulus();
         begin
            int waitCycles;
            waitCycles = 0;
            @(negedge clk50);
            while (!writeGate && waitCycles < 50) begin
               @(negedge clk50);
               waitCycles++;
            end
            checkSignal("abort gate rose", writeGate, 1'b1);
            repeat (7 * WIN + 2) @(negedge clk50);
         end
      join
      checkSignal("pre-abort write_gate", writeGate, 1'b1);
      reset = 1'b1;
      #1;
      checkSignal("abort raw_mfm", rawMfm, 1'b0);
      checkSignal("abort write_gate", writeGate, 1'b0);
      checkSignal("abort busy", busy, 1'b0);
      checkSignal("abort data_ready", dataReady, 1'b0);
      repeat (2) @(negedge clk50);
      reset = 1'b0;
      @(negedge clk50);
      checkSignal("after-abort data_ready", dataReady, 1'b1);
      checkSignal("after-abort write_gate", writeGate, 1'b0);
      runStream("restart-00");

      // Random streams against the reference model
      for (int r = 0; r < 25; r++) begin
         logic p;
         streamLen = int'($urandom_range(1, 3));
         p = 1'b0;
         for (int i = 0; i < streamLen; i++) begin
            streamData[i] = 8'($urandom);
            streamSync[i] = ($urandom_range(0, 3) == 0);
            expWords[i]   = mfmWord(p, streamData[i], streamSync[i]);
            p = streamData[i][0];
         end
         runStream($sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
